// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle pre-emption arbiter for the T-junction light controller.
// Optional grant timeout is built in when EM_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no emergency activity, waiting for a request
// CLEAR   | clearance interval, tgt_r selects the approach granted next
// GRANT_L | left approach pre-empted (green)
// GRANT_R | right approach pre-empted (green)
module emergency_preempt_arbiter #(
   parameter int T_EM  = 9,
   parameter int T_CLR = 3,
   parameter int T_MAX = 30,
   parameter int CNT_W = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic req_left,
   input  logic req_right,
   output logic grant_left,
   output logic grant_right,
   output logic clearing,
   output logic busy,
   output logic em_fault
);

   typedef enum logic [1:0] {IDLE, CLEAR, GRANT_L, GRANT_R} state_t;

   if ((2 ** CNT_W) <= T_EM || (2 ** CNT_W) <= T_CLR || (2 ** CNT_W) <= T_MAX) begin : g_cnt_w_check
      $error("CNT_W too narrow for T_EM/T_CLR/T_MAX");
   end

   state_t           state, state_nxt;
   logic             tgt_r, tgt_r_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pend_l, pend_r, pend_l_nxt, pend_r_nxt;
   logic             eff_l, eff_r;
   logic             want_l, want_r;
   logic             timeout;

`ifdef EM_TIMEOUT_EN
   logic [CNT_W-1:0] tcnt;
   logic             blk_l, blk_r, fault;

   // A timed-out request is ignored until its line has been seen low once.
   assign eff_l   = req_left  & ~blk_l;
   assign eff_r   = req_right & ~blk_r;
   assign timeout = (tcnt == CNT_W'(T_MAX - 1)) &&
                    ((state == GRANT_L && req_left && !want_r) ||
                     (state == GRANT_R && req_right));
   assign em_fault = fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt  <= '0;
         blk_l <= 1'b0;
         blk_r <= 1'b0;
         fault <= 1'b0;
      end else begin
         if (state_nxt == state && (state == GRANT_L || state == GRANT_R))
            tcnt <= tcnt + 1'b1;
         else
            tcnt <= '0;
         if (timeout && state == GRANT_L) blk_l <= 1'b1;
         else if (!req_left)              blk_l <= 1'b0;
         if (timeout && state == GRANT_R) blk_r <= 1'b1;
         else if (!req_right)             blk_r <= 1'b0;
         if (timeout) fault <= 1'b1;
      end
   end
`else
   assign eff_l    = req_left;
   assign eff_r    = req_right;
   assign timeout  = 1'b0;
   assign em_fault = 1'b0;
`endif

   assign want_l = pend_l | eff_l;
   assign want_r = pend_r | eff_r;

   always_comb begin
      state_nxt = state;
      tgt_r_nxt = tgt_r;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (want_r) begin
               state_nxt = CLEAR;
               tgt_r_nxt = 1'b1;
            end else if (want_l) begin
               state_nxt = CLEAR;
               tgt_r_nxt = 1'b0;
            end
         end
         CLEAR: begin
            if (want_r) tgt_r_nxt = 1'b1;
            if (cnt == CNT_W'(T_CLR - 1)) begin
               state_nxt = tgt_r_nxt ? GRANT_R : GRANT_L;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GRANT_L: begin
            if (cnt < CNT_W'(T_EM)) cnt_nxt = cnt + 1'b1;
            // Right pre-empts left immediately, whatever the grant age.
            if (want_r) begin
               state_nxt = CLEAR;
               tgt_r_nxt = 1'b1;
               cnt_nxt   = '0;
            end else if ((cnt >= CNT_W'(T_EM - 1) && !req_left) || timeout) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         GRANT_R: begin
            if (cnt < CNT_W'(T_EM)) cnt_nxt = cnt + 1'b1;
            if ((cnt >= CNT_W'(T_EM - 1) && !req_right) || timeout) begin
               cnt_nxt = '0;
               if (want_l) begin
                  state_nxt = CLEAR;
                  tgt_r_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Entering the grant clears the latch, taking precedence over a same-cycle set.
   assign pend_l_nxt = (pend_l | (eff_l & (state != GRANT_L))) & (state_nxt != GRANT_L);
   assign pend_r_nxt = (pend_r | (eff_r & (state != GRANT_R))) & (state_nxt != GRANT_R);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         tgt_r  <= 1'b0;
         cnt    <= '0;
         pend_l <= 1'b0;
         pend_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         tgt_r  <= tgt_r_nxt;
         cnt    <= cnt_nxt;
         pend_l <= pend_l_nxt;
         pend_r <= pend_r_nxt;
      end
   end

   assign grant_left  = (state == GRANT_L);
   assign grant_right = (state == GRANT_R);
   assign clearing    = (state == CLEAR);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Scoreboard bench for emergency_preempt_arbiter: directed scenarios then random requests,
// expected outputs from a phase/elapsed-time reference model.
module tb_emergency_preempt_arbiter;

   localparam int T_EM  = 9;
   localparam int T_CLR = 3;
   localparam int T_MAX = 30;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req_left = 1'b0;
   logic req_right = 1'b0;
   logic grant_left, grant_right, clearing, busy, em_fault;

   emergency_preempt_arbiter #(.T_EM(T_EM), .T_CLR(T_CLR), .T_MAX(T_MAX), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .req_left(req_left), .req_right(req_right),
      .grant_left(grant_left), .grant_right(grant_right), .clearing(clearing),
      .busy(busy), .em_fault(em_fault)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_cycle = 0;
   logic [4:0] exp_q[$];

   // reference model: phase 0 idle, 1 clearing, 2 granted; m_t = cycles shown in phase
   int m_phase = 0;
   bit m_right = 1'b0;
   int m_t = 0;
   bit m_pl = 1'b0, m_pr = 1'b0, m_bl = 1'b0, m_br = 1'b0, m_fault = 1'b0;

   function automatic logic [4:0] model_out();
      return {m_phase == 2 && !m_right, m_phase == 2 && m_right, m_phase == 1,
              m_phase != 0, m_fault};
   endfunction

   task automatic model_exit_grant(input bit wl);
      if (m_right && wl) begin
         m_phase = 1; m_right = 1'b0; m_t = 1;
      end else begin
         m_phase = 0; m_t = 0;
      end
   endtask

   task automatic model_step(input bit rl, input bit rr, input bit rst);
      bit el, er, wl, wr, was_gl, was_gr, to_hit, own;
      if (rst) begin
         m_phase = 0; m_t = 0; m_right = 1'b0;
         m_pl = 1'b0; m_pr = 1'b0; m_bl = 1'b0; m_br = 1'b0; m_fault = 1'b0;
         return;
      end
      el = rl && !m_bl;
      er = rr && !m_br;
      wl = m_pl || el;
      wr = m_pr || er;
      was_gl = (m_phase == 2) && !m_right;
      was_gr = (m_phase == 2) && m_right;
      own = m_right ? rr : rl;
      to_hit = 1'b0;
      case (m_phase)
         0: begin
            if (wr)      begin m_phase = 1; m_right = 1'b1; m_t = 1; end
            else if (wl) begin m_phase = 1; m_right = 1'b0; m_t = 1; end
         end
         1: begin
            if (wr) m_right = 1'b1;
            if (m_t == T_CLR) begin m_phase = 2; m_t = 1; end
            else m_t++;
         end
         default: begin
            if (!m_right && wr) begin
               m_phase = 1; m_right = 1'b1; m_t = 1;
            end else if (m_t >= T_EM && !own) begin
               model_exit_grant(wl);
`ifdef EM_TIMEOUT_EN
            end else if (m_t >= T_MAX) begin
               to_hit = 1'b1;
               model_exit_grant(wl);
`endif
            end else begin
               m_t++;
            end
         end
      endcase
      m_pl = (m_pl || (el && !was_gl)) && !(m_phase == 2 && !m_right);
      m_pr = (m_pr || (er && !was_gr)) && !(m_phase == 2 && m_right);
      if (to_hit && was_gl) m_bl = 1'b1; else if (!rl) m_bl = 1'b0;
      if (to_hit && was_gr) m_br = 1'b1; else if (!rr) m_br = 1'b0;
      if (to_hit) m_fault = 1'b1;
   endtask

   task automatic cyc(input bit rl, input bit rr, input bit rst);
      @(negedge clk);
      req_left = rl;
      req_right = rr;
      reset = rst;
      model_step(rl, rr, rst);
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   // run lengths of the most recent completed output pulses
   int gl_run = 0, gr_run = 0, clr_run = 0;
   int last_gl = 0, last_gr = 0, last_clr = 0;

   always @(posedge clk) begin
      logic [4:0] exp_v, act_v;
      #1;
      n_cycle++;
      act_v = {grant_left, grant_right, clearing, busy, em_fault};
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         n_total++;
         if (act_v === exp_v) n_pass++;
         else $display("FAIL outputs cyc %0d {gl,gr,clr,busy,fault}: got %b want %b",
                       n_cycle, act_v, exp_v);
      end
      if (grant_left) gl_run++; else if (gl_run > 0) begin last_gl = gl_run; gl_run = 0; end
      if (grant_right) gr_run++; else if (gr_run > 0) begin last_gr = gr_run; gr_run = 0; end
      if (clearing) clr_run++; else if (clr_run > 0) begin last_clr = clr_run; clr_run = 0; end
   end

   task automatic check_len(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, req);
   endtask

   int hold_l, hold_r;
   bit lvl_l, lvl_r;

   initial begin
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      idle(2);

      // single-cycle left pulse
      cyc(1'b1, 1'b0, 1'b0);
      idle(16);
      check_len("pulse_left_grant", last_gl, T_EM);
      check_len("pulse_left_clear", last_clr, T_CLR);

      // right held 15 cycles
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0);
      idle(6);
      check_len("held_right_grant", last_gr, 12);

      // simultaneous: right 15, left 20
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
      idle(14);
      check_len("both_right_grant", last_gr, 12);
      check_len("both_left_grant", last_gl, T_EM);

      // left pre-empted by right during grant
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      cyc(1'b0, 1'b1, 1'b0);
      idle(16);
      check_len("preempted_left_grant", last_gl, 2);
      check_len("preempting_right_grant", last_gr, T_EM);

      // right pulse in clearance overrides left target
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      idle(40);

      // reset mid-grant with a latched left request
      cyc(1'b0, 1'b1, 1'b0);
      idle(4);
      cyc(1'b1, 1'b0, 1'b0);
      idle(1);
      cyc(1'b0, 1'b0, 1'b1);
      idle(20);
      check_len("reset_cut_right_grant", last_gr, 4);

`ifdef EM_TIMEOUT_EN
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0);
      idle(5);
      check_len("timeout_right_grant", last_gr, T_MAX);
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0);
      idle(20);
`endif

      // randomized request levels with occasional reset
      hold_l = 0; hold_r = 0; lvl_l = 1'b0; lvl_r = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (hold_l == 0) begin
            lvl_l = ($urandom_range(0, 2) == 0);
            hold_l = lvl_l ? $urandom_range(1, 25) : $urandom_range(1, 30);
         end
         if (hold_r == 0) begin
            lvl_r = ($urandom_range(0, 3) == 0);
            hold_r = lvl_r ? $urandom_range(1, 20) : $urandom_range(1, 40);
         end
         hold_l--; hold_r--;
         cyc(lvl_l, lvl_r, $urandom_range(0, 299) == 0);
      end
      idle(40);

      repeat (2) @(posedge clk);
      #2;
      check_len("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
